// File: rtl/hex_rate_counter_if.sv
// Bundles the control inputs and display outputs of hex_rate_counter.
// master drives the controls; slave is the counter side.
interface hex_rate_counter_if;
    logic       enable;
    logic [1:0] speed;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] q;
    logic       tick;
    logic       wrap;

    modport master (
        output enable, speed, load, load_value,
        input  q, tick, wrap
    );

    modport slave (
        input  enable, speed, load, load_value,
        output q, tick, wrap
    );
endinterface

// File: rtl/hex_rate_counter.sv
// Rate-divided 4-bit up-counter feeding a 7-segment hex decoder.
// Define HEX_RATE_COUNTER_BCD_EN to build a decade (0..9) counter instead of full hex.
module hex_rate_counter #(
    parameter int unsigned CLOCK_HZ = 50_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hex_rate_counter_if.slave bus_io
);

    localparam int unsigned DIV_W = $clog2(4 * CLOCK_HZ);

`ifdef HEX_RATE_COUNTER_BCD_EN
    localparam logic [3:0] QMax = 4'h9;
`else
    localparam logic [3:0] QMax = 4'hF;
`endif

    logic [DIV_W-1:0] rate_cnt_d, rate_cnt_q;
    logic [DIV_W-1:0] reload_val;
    logic [1:0]       speed_d, speed_q;
    logic [3:0]       q_d, q_q;
    logic [3:0]       load_val;
    logic [3:0]       q_inc;
    logic             tick_d, tick_q;
    logic             wrap_d, wrap_q;
    logic             speed_chg;
    logic             hit;

    // Divider reload is one less than the step period for the current Speed.
    always_comb begin
        case (bus_io.speed)
            2'b00:   reload_val = '0;
            2'b01:   reload_val = DIV_W'(CLOCK_HZ - 1);
            2'b10:   reload_val = DIV_W'(2 * CLOCK_HZ - 1);
            default: reload_val = DIV_W'(4 * CLOCK_HZ - 1);
        endcase
    end

`ifdef HEX_RATE_COUNTER_BCD_EN
    assign load_val = (bus_io.load_value > QMax) ? QMax : bus_io.load_value;
`else
    assign load_val = bus_io.load_value;
`endif

    assign q_inc     = (q_q == QMax) ? 4'h0 : q_q + 4'h1;
    assign speed_chg = (bus_io.speed != speed_q);
    assign hit       = bus_io.enable && (rate_cnt_q == '0) && !speed_chg;

    always_comb begin
        speed_d    = bus_io.speed;
        q_d        = q_q;
        rate_cnt_d = rate_cnt_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        if (bus_io.load) begin
            q_d        = load_val;
            rate_cnt_d = reload_val;
        end else if (speed_chg) begin
            // Restart the period cleanly at the new rate; no step this cycle.
            rate_cnt_d = reload_val;
        end else if (hit) begin
            q_d        = q_inc;
            tick_d     = 1'b1;
            wrap_d     = (q_q == QMax);
            rate_cnt_d = reload_val;
        end else if (bus_io.enable) begin
            rate_cnt_d = rate_cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q        <= 4'h0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            rate_cnt_q <= reload_val;
            speed_q    <= bus_io.speed;
        end else begin
            q_q        <= q_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            rate_cnt_q <= rate_cnt_d;
            speed_q    <= speed_d;
        end
    end

    assign bus_io.q    = q_q;
    assign bus_io.tick = tick_q;
    assign bus_io.wrap = wrap_q;

    // A rollover is always a step that lands on zero.
    a_wrap_is_step: assert property (@(posedge clk_i) disable iff (rst_i)
        wrap_q |-> (tick_q && (q_q == 4'h0)));

endmodule

// File: tb/tb_hex_rate_counter.sv
// Scoreboard bench for hex_rate_counter at CLOCK_HZ=4; follows HEX_RATE_COUNTER_BCD_EN.
module tb_hex_rate_counter;

    localparam int unsigned CLOCK_HZ = 4;
`ifdef HEX_RATE_COUNTER_BCD_EN
    localparam int QMAX = 9;
`else
    localparam int QMAX = 15;
`endif

    typedef struct packed {
        logic [3:0] q;
        logic       tick;
        logic       wrap;
    } exp_t;

    logic clk;
    logic rst;
    hex_rate_counter_if bus ();

    hex_rate_counter #(
        .CLOCK_HZ (CLOCK_HZ)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    // Reference state, updated from the behavioural description each cycle.
    int         m_q;
    int         m_rc;
    logic [1:0] m_spd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int period(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return CLOCK_HZ;
            2'b10:   return 2 * CLOCK_HZ;
            default: return 4 * CLOCK_HZ;
        endcase
    endfunction

    task automatic cycle(input logic r, input logic en, input logic [1:0] spd,
                         input logic ld, input logic [3:0] lv);
        exp_t e;
        exp_t got;
        bit   chg;
        rst            = r;
        bus.enable     = en;
        bus.speed      = spd;
        bus.load       = ld;
        bus.load_value = lv;
        e.tick = 1'b0;
        e.wrap = 1'b0;
        if (r) begin
            m_q   = 0;
            m_rc  = period(spd) - 1;
            m_spd = spd;
        end else begin
            chg   = (spd != m_spd);
            m_spd = spd;
            if (ld) begin
                m_q  = (int'(lv) > QMAX) ? QMAX : int'(lv);
                m_rc = period(spd) - 1;
            end else if (chg) begin
                m_rc = period(spd) - 1;
            end else if (en && m_rc == 0) begin
                e.wrap = (m_q == QMAX);
                m_q    = (m_q == QMAX) ? 0 : m_q + 1;
                e.tick = 1'b1;
                m_rc   = period(spd) - 1;
            end else if (en) begin
                m_rc = m_rc - 1;
            end
        end
        e.q = 4'(m_q);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_eq("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            got.q    = bus.q;
            got.tick = bus.tick;
            got.wrap = bus.wrap;
            e = exp_q.pop_front();
            check_eq("q", got.q, e.q);
            check_eq("tick", got.tick, e.tick);
            check_eq("wrap", got.wrap, e.wrap);
        end
    endtask

    task automatic run(input int n, input logic en, input logic [1:0] spd);
        for (int i = 0; i < n; i++) cycle(1'b0, en, spd, 1'b0, 4'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_q = 0;
        m_rc = 0;
        m_spd = 2'b00;

        // Reset then Speed=01: steps at 4, 8, 12 cycles.
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 4'h0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 4'h0);
        check_eq("rst_q", bus.q, 0);
        run(3, 1'b1, 2'b01);
        check_eq("s1_hold", bus.q, 0);
        run(1, 1'b1, 2'b01);
        check_eq("s1_first", bus.q, 1);
        check_eq("s1_tick", bus.tick, 1);
        run(8, 1'b1, 2'b01);
        check_eq("s1_three", bus.q, 3);

        // Speed=00 counts every cycle.
        cycle(1'b1, 1'b1, 2'b00, 1'b0, 4'h0);
        run(16, 1'b1, 2'b00);
        check_eq("s2_q16", bus.q, 16 % (QMAX + 1));
        check_eq("s2_wrap", bus.wrap, (QMAX == 15) ? 1 : 0);

        // Speed=10 with a 3-cycle Enable gap delays the step by 3.
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 4'h0);
        run(3, 1'b1, 2'b10);
        run(3, 1'b0, 2'b10);
        check_eq("s3_frozen", bus.q, 0);
        run(4, 1'b1, 2'b10);
        check_eq("s3_late", bus.q, 0);
        run(1, 1'b1, 2'b10);
        check_eq("s3_step", bus.q, 1);

        // Load with Enable=0, then count through rollover.
        cycle(1'b1, 1'b0, 2'b01, 1'b0, 4'h0);
        cycle(1'b0, 1'b0, 2'b01, 1'b1, 4'hE);
        check_eq("s4_load", bus.q, (QMAX == 15) ? 14 : 9);
        check_eq("s4_ltick", bus.tick, 0);
        run(4, 1'b1, 2'b01);
        run(4, 1'b1, 2'b01);

        // Speed 01 -> 11 two cycles into a period.
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 4'h0);
        run(2, 1'b1, 2'b01);
        run(16, 1'b1, 2'b11);
        check_eq("s5_nostep", bus.q, 0);
        run(1, 1'b1, 2'b11);
        check_eq("s5_step", bus.q, 1);
        cycle(1'b1, 1'b1, 2'b11, 1'b1, 4'h5);
        check_eq("s5_rst_ld", bus.q, 0);

        // Load 8 at full rate, then an out-of-range load.
        cycle(1'b0, 1'b1, 2'b00, 1'b1, 4'h8);
        run(2, 1'b1, 2'b00);
        cycle(1'b0, 1'b1, 2'b00, 1'b1, 4'hC);
        check_eq("s6_ldc", bus.q, (QMAX == 15) ? 12 : 9);
        run(3, 1'b1, 2'b00);

        // Random soak.
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic       en;
            logic       ld;
            logic [1:0] spd;
            r   = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            spd = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : m_spd;
            cycle(r, en, spd, ld, 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
